// File: rtl/test_pattern_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// test_pattern_sequencer_pkg
// Shared definitions for the test pattern sequencer:
//   - TP_SEL / TP_COLOR encodings understood by the pattern generator
//   - the 7-entry automatic playlist as constants plus a lookup function
//   - sequencer FSM state encoding
// -----------------------------------------------------------------------------
package test_pattern_sequencer_pkg;

   localparam int PLAYLIST_LEN = 7;

   typedef enum logic [1:0] {
      SEL_BARS     = 2'b00,
      SEL_PLAIN    = 2'b01,
      SEL_BLACK    = 2'b10,
      SEL_GRADIENT = 2'b11
   } tp_sel_t;

   typedef enum logic [1:0] {
      COLOR_GREY  = 2'b00,
      COLOR_RED   = 2'b01,
      COLOR_GREEN = 2'b10,
      COLOR_BLUE  = 2'b11
   } tp_color_t;

   typedef struct packed {
      tp_sel_t   sel;
      tp_color_t color;
   } tp_entry_t;

   typedef enum logic {
      ST_MANUAL = 1'b0,
      ST_AUTO   = 1'b1
   } seq_state_t;

   // Playlist ROM, index 0..6
   localparam tp_entry_t PL_BARS     = '{sel: SEL_BARS,     color: COLOR_GREY};
   localparam tp_entry_t PL_GREY     = '{sel: SEL_PLAIN,    color: COLOR_GREY};
   localparam tp_entry_t PL_RED      = '{sel: SEL_PLAIN,    color: COLOR_RED};
   localparam tp_entry_t PL_GREEN    = '{sel: SEL_PLAIN,    color: COLOR_GREEN};
   localparam tp_entry_t PL_BLUE     = '{sel: SEL_PLAIN,    color: COLOR_BLUE};
   localparam tp_entry_t PL_BLACK    = '{sel: SEL_BLACK,    color: COLOR_GREY};
   localparam tp_entry_t PL_GRADIENT = '{sel: SEL_GRADIENT, color: COLOR_GREY};

   function automatic tp_entry_t playlist_entry(input logic [2:0] idx);
      tp_entry_t e;
      case (idx)
         3'd0:    e = PL_BARS;
         3'd1:    e = PL_GREY;
         3'd2:    e = PL_RED;
         3'd3:    e = PL_GREEN;
         3'd4:    e = PL_BLUE;
         3'd5:    e = PL_BLACK;
         3'd6:    e = PL_GRADIENT;
         default: e = PL_BARS;
      endcase
      return e;
   endfunction

   function automatic logic [2:0] next_idx(input logic [2:0] idx);
      return (idx == 3'(PLAYLIST_LEN - 1)) ? 3'd0 : idx + 3'd1;
   endfunction

endpackage

// File: rtl/test_pattern_sequencer_if.sv
// -----------------------------------------------------------------------------
// test_pattern_sequencer_if
// Bundles the control inputs (frame sync, mode, manual selects, step) and the
// selector/status outputs of the sequencer.
//   master : board controls / host side (drives controls, observes outputs)
//   slave  : the sequencer itself
// -----------------------------------------------------------------------------
interface test_pattern_sequencer_if;
   logic        FRAME_START;
   logic        MODE_AUTO;
   logic [1:0]  MAN_SEL;
   logic [1:0]  MAN_COLOR;
   logic        STEP;
   logic [1:0]  TP_SEL;
   logic [1:0]  TP_COLOR;
   logic [7:0]  BREATH_LEVEL;
   logic [2:0]  SEQ_IDX;
   logic [15:0] FRAME_CNT;

   modport master (
      output FRAME_START, MODE_AUTO, MAN_SEL, MAN_COLOR, STEP,
      input  TP_SEL, TP_COLOR, BREATH_LEVEL, SEQ_IDX, FRAME_CNT
   );

   modport slave (
      input  FRAME_START, MODE_AUTO, MAN_SEL, MAN_COLOR, STEP,
      output TP_SEL, TP_COLOR, BREATH_LEVEL, SEQ_IDX, FRAME_CNT
   );
endinterface

// File: rtl/test_pattern_sequencer_breath_level_gen.sv
// -----------------------------------------------------------------------------
// test_pattern_sequencer_breath_level_gen
// Triangle-wave grey-breath level. Each enable (one per frame) bumps a frame
// divider; when the divider wraps the 8-bit level moves one step up or down.
// Ports:
//   clk   : pixel clock
//   rst_n : asynchronous active-low reset
//   en    : frame-start strobe
//   level : breath level 0..255 (registered)
// -----------------------------------------------------------------------------
module test_pattern_sequencer_breath_level_gen #(
   parameter int BREATH_DIV = 2,
   parameter int CNT_W      = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   output logic [7:0] level
);

   localparam int              DIV_EFF  = (BREATH_DIV < 1) ? 1 : BREATH_DIV;
   localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_EFF - 1);

   logic [CNT_W-1:0] div_reg;
   logic [7:0]       level_reg;
   logic             dir_up_reg;

   // The direction flips on the step that lands on an extreme, so each
   // extreme is shown for exactly one step and the period is 510 steps.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_reg    <= '0;
         level_reg  <= 8'd0;
         dir_up_reg <= 1'b1;
      end else if (en) begin
         if (div_reg == DIV_LAST) begin
            div_reg <= '0;
            if (dir_up_reg) begin
               level_reg <= level_reg + 8'd1;
               if (level_reg == 8'hFE) dir_up_reg <= 1'b0;
            end else begin
               level_reg <= level_reg - 8'd1;
               if (level_reg == 8'h01) dir_up_reg <= 1'b1;
            end
         end else begin
            div_reg <= div_reg + CNT_W'(1);
         end
      end
   end

   assign level = level_reg;

endmodule

// File: rtl/test_pattern_sequencer.sv
// -----------------------------------------------------------------------------
// test_pattern_sequencer
// Frame-synchronous selector for the test pattern generator. In manual mode
// TP_SEL/TP_COLOR follow the manual inputs; in auto mode they step through a
// 7-entry playlist, dwelling DWELL_FRAMES frames per entry or advancing early
// on a STEP request. All state changes happen only on FRAME_START.
// Ports:
//   PCLK    : pixel clock
//   RESET_N : asynchronous active-low reset
//   bus     : controls in (FRAME_START, MODE_AUTO, MAN_SEL, MAN_COLOR, STEP),
//             outputs (TP_SEL, TP_COLOR, BREATH_LEVEL, SEQ_IDX, FRAME_CNT)
// -----------------------------------------------------------------------------
module test_pattern_sequencer
   import test_pattern_sequencer_pkg::*;
#(
   parameter int DWELL_FRAMES = 120,
   parameter int BREATH_DIV   = 2,
   parameter int CNT_W        = 8
) (
   input  logic                     PCLK,
   input  logic                     RESET_N,
   test_pattern_sequencer_if.slave  bus
);

   localparam int               DWELL_EFF  = (DWELL_FRAMES < 1) ? 1 : DWELL_FRAMES;
   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_EFF - 1);

   seq_state_t       state_reg;
   logic [CNT_W-1:0] dwell_reg;
   logic             step_pending_reg;
   logic [2:0]       seq_idx_reg;
   logic [1:0]       tp_sel_reg;
   logic [1:0]       tp_color_reg;
   logic [15:0]      frame_cnt_reg;
   logic [7:0]       breath_level;

   always_ff @(posedge PCLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_reg        <= ST_MANUAL;
         dwell_reg        <= '0;
         step_pending_reg <= 1'b0;
         seq_idx_reg      <= 3'd0;
         tp_sel_reg       <= 2'b00;
         tp_color_reg     <= 2'b00;
         frame_cnt_reg    <= 16'd0;
      end else if (bus.FRAME_START) begin
         frame_cnt_reg    <= frame_cnt_reg + 16'd1;
         // Every frame either consumes a pending step or is in manual mode,
         // where steps are meaningless, so the request always clears here.
         step_pending_reg <= 1'b0;
         case (state_reg)
            ST_MANUAL: begin
               if (bus.MODE_AUTO) begin
                  state_reg                  <= ST_AUTO;
                  dwell_reg                  <= '0;
                  {tp_sel_reg, tp_color_reg} <= playlist_entry(seq_idx_reg);
               end else begin
                  tp_sel_reg   <= bus.MAN_SEL;
                  tp_color_reg <= bus.MAN_COLOR;
               end
            end
            ST_AUTO: begin
               if (!bus.MODE_AUTO) begin
                  state_reg    <= ST_MANUAL;
                  tp_sel_reg   <= bus.MAN_SEL;
                  tp_color_reg <= bus.MAN_COLOR;
               end else if (dwell_reg == DWELL_LAST || step_pending_reg || bus.STEP) begin
                  // Expiry and a step request on the same frame merge into one advance.
                  seq_idx_reg                <= next_idx(seq_idx_reg);
                  dwell_reg                  <= '0;
                  {tp_sel_reg, tp_color_reg} <= playlist_entry(next_idx(seq_idx_reg));
               end else begin
                  dwell_reg <= dwell_reg + CNT_W'(1);
               end
            end
            default: state_reg <= ST_MANUAL;
         endcase
      end else if (state_reg == ST_AUTO && bus.STEP) begin
         step_pending_reg <= 1'b1;
      end
   end

   test_pattern_sequencer_breath_level_gen #(
      .BREATH_DIV (BREATH_DIV),
      .CNT_W      (CNT_W)
   ) u_breath (
      .clk   (PCLK),
      .rst_n (RESET_N),
      .en    (bus.FRAME_START),
      .level (breath_level)
   );

   assign bus.TP_SEL       = tp_sel_reg;
   assign bus.TP_COLOR     = tp_color_reg;
   assign bus.BREATH_LEVEL = breath_level;
   assign bus.SEQ_IDX      = seq_idx_reg;
   assign bus.FRAME_CNT    = frame_cnt_reg;

endmodule

// File: tb/tb_test_pattern_sequencer.sv
// -----------------------------------------------------------------------------
// tb_test_pattern_sequencer
// Directed bench. dut runs with DWELL_FRAMES=3, BREATH_DIV=1; dut_dflt runs
// with default parameters on the same stimulus and is used for its breath
// level (BREATH_DIV=2).
// -----------------------------------------------------------------------------
module tb_test_pattern_sequencer;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   test_pattern_sequencer_if bus_a ();
   test_pattern_sequencer_if bus_b ();

   assign bus_b.FRAME_START = bus_a.FRAME_START;
   assign bus_b.MODE_AUTO   = bus_a.MODE_AUTO;
   assign bus_b.MAN_SEL     = bus_a.MAN_SEL;
   assign bus_b.MAN_COLOR   = bus_a.MAN_COLOR;
   assign bus_b.STEP        = bus_a.STEP;

   test_pattern_sequencer #(.DWELL_FRAMES(3), .BREATH_DIV(1), .CNT_W(8)) dut (
      .PCLK(clk), .RESET_N(rst_n), .bus(bus_a));

   test_pattern_sequencer dut_dflt (
      .PCLK(clk), .RESET_N(rst_n), .bus(bus_b));

   int n_checks = 0;
   int n_fail   = 0;
   int frames   = 0;

   // Hand-written playlist: index -> (sel, color)
   logic [1:0] pl_sel [7] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b11};
   logic [1:0] pl_col [7] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b00};

   // Triangle: steps s = f/div, rises 0..255 then falls to 0 at s=510.
   function automatic int exp_level(input int f, input int div);
      int m;
      m = (f / div) % 510;
      return (m <= 255) ? m : 510 - m;
   endfunction

   task automatic do_frame(input bit with_step);
      @(posedge clk); #1;
      bus_a.FRAME_START = 1'b1;
      bus_a.STEP        = with_step;
      @(posedge clk); #1;
      bus_a.FRAME_START = 1'b0;
      bus_a.STEP        = 1'b0;
      frames++;
      $display("frame %0d step=%0b: seq=%0d sel=%b color=%b level=%0d/%0d cnt=%0d",
               frames, with_step, bus_a.SEQ_IDX, bus_a.TP_SEL, bus_a.TP_COLOR,
               bus_a.BREATH_LEVEL, bus_b.BREATH_LEVEL, bus_a.FRAME_CNT);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_step;
      @(posedge clk); #1 bus_a.STEP = 1'b1;
      @(posedge clk); #1 bus_a.STEP = 1'b0;
      $display("step pulse: seq=%0d", bus_a.SEQ_IDX);
   endtask

   task automatic test_reset;
      bus_a.FRAME_START = 1'b0;
      bus_a.MODE_AUTO   = 1'b0;
      bus_a.MAN_SEL     = 2'b00;
      bus_a.MAN_COLOR   = 2'b00;
      bus_a.STEP        = 1'b0;
      rst_n = 1'b0;
      idle(3);
      n_checks++;
      if ({bus_a.TP_SEL, bus_a.TP_COLOR, bus_a.BREATH_LEVEL, bus_a.SEQ_IDX, bus_a.FRAME_CNT} !== 31'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got sel=%b col=%b lvl=%0d idx=%0d cnt=%0d, expected all 0",
                  bus_a.TP_SEL, bus_a.TP_COLOR, bus_a.BREATH_LEVEL, bus_a.SEQ_IDX, bus_a.FRAME_CNT);
      end
      rst_n = 1'b1;
      frames = 0;
      bus_a.MAN_SEL   = 2'b01;
      bus_a.MAN_COLOR = 2'b10;
      idle(3);
      n_checks++;
      if ({bus_a.TP_SEL, bus_a.TP_COLOR} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_hold_no_frame: got sel/col=%b expected 0000", {bus_a.TP_SEL, bus_a.TP_COLOR});
      end
      do_frame(1'b0);
      n_checks++;
      if (bus_a.TP_SEL !== 2'b01) begin
         n_fail++; $display("FAIL first_frame_sel: got %b expected 01", bus_a.TP_SEL);
      end
      n_checks++;
      if (bus_a.TP_COLOR !== 2'b10) begin
         n_fail++; $display("FAIL first_frame_color: got %b expected 10", bus_a.TP_COLOR);
      end
      n_checks++;
      if (bus_a.FRAME_CNT !== 16'd1) begin
         n_fail++; $display("FAIL first_frame_cnt: got %0d expected 1", bus_a.FRAME_CNT);
      end
      n_checks++;
      if (bus_b.BREATH_LEVEL !== 8'd0) begin
         n_fail++; $display("FAIL first_frame_level_div2: got %0d expected 0", bus_b.BREATH_LEVEL);
      end
      n_checks++;
      if (bus_a.BREATH_LEVEL !== 8'd1) begin
         n_fail++; $display("FAIL first_frame_level_div1: got %0d expected 1", bus_a.BREATH_LEVEL);
      end
      n_checks++;
      if (bus_a.SEQ_IDX !== 3'd0) begin
         n_fail++; $display("FAIL first_frame_idx: got %0d expected 0", bus_a.SEQ_IDX);
      end
      bus_a.MAN_SEL = 2'b11;
      idle(3);
      n_checks++;
      if (bus_a.TP_SEL !== 2'b01 || bus_a.FRAME_CNT !== 16'd1) begin
         n_fail++;
         $display("FAIL midframe_hold: got sel=%b cnt=%0d expected sel=01 cnt=1", bus_a.TP_SEL, bus_a.FRAME_CNT);
      end
   endtask

   task automatic test_auto_playlist;
      int e;
      bus_a.MODE_AUTO = 1'b1;
      idle(2);
      for (int k = 0; k < 22; k++) begin
         do_frame(1'b0);
         e = (k / 3) % 7;
         n_checks++;
         if (bus_a.SEQ_IDX !== 3'(e)) begin
            n_fail++; $display("FAIL auto_idx[%0d]: got %0d expected %0d", k, bus_a.SEQ_IDX, e);
         end
         n_checks++;
         if ({bus_a.TP_SEL, bus_a.TP_COLOR} !== {pl_sel[e], pl_col[e]}) begin
            n_fail++;
            $display("FAIL auto_entry[%0d]: got sel=%b col=%b expected sel=%b col=%b",
                     k, bus_a.TP_SEL, bus_a.TP_COLOR, pl_sel[e], pl_col[e]);
         end
         n_checks++;
         if (bus_a.FRAME_CNT !== 16'(frames)) begin
            n_fail++; $display("FAIL auto_cnt[%0d]: got %0d expected %0d", k, bus_a.FRAME_CNT, frames);
         end
      end
   endtask

   task automatic test_step;
      // Starts at index 0, dwell 0. Steps coincide with frames 6 and 10.
      int exp_idx [12] = '{1, 1, 1, 2, 2, 2, 3, 3, 3, 4, 5, 5};
      bit step_on [12] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0};
      pulse_step();
      idle(1);
      pulse_step();
      idle(1);
      n_checks++;
      if (bus_a.SEQ_IDX !== 3'd0) begin
         n_fail++; $display("FAIL step_midframe_hold: got %0d expected 0", bus_a.SEQ_IDX);
      end
      for (int k = 0; k < 12; k++) begin
         do_frame(step_on[k]);
         n_checks++;
         if (bus_a.SEQ_IDX !== 3'(exp_idx[k])) begin
            n_fail++; $display("FAIL step_idx[%0d]: got %0d expected %0d", k, bus_a.SEQ_IDX, exp_idx[k]);
         end
         n_checks++;
         if ({bus_a.TP_SEL, bus_a.TP_COLOR} !== {pl_sel[exp_idx[k]], pl_col[exp_idx[k]]}) begin
            n_fail++;
            $display("FAIL step_entry[%0d]: got sel=%b col=%b expected sel=%b col=%b", k,
                     bus_a.TP_SEL, bus_a.TP_COLOR, pl_sel[exp_idx[k]], pl_col[exp_idx[k]]);
         end
      end
   endtask

   task automatic test_mode_toggle;
      // Starts at index 5, dwell 1.
      int exp_idx [4] = '{5, 5, 5, 6};
      bus_a.MAN_SEL   = 2'b11;
      bus_a.MAN_COLOR = 2'b11;
      bus_a.MODE_AUTO = 1'b0;
      idle(2);
      n_checks++;
      if ({bus_a.TP_SEL, bus_a.TP_COLOR, bus_a.SEQ_IDX} !== {2'b10, 2'b00, 3'd5}) begin
         n_fail++;
         $display("FAIL toggle_off_midframe: got sel=%b col=%b idx=%0d expected 10 00 5",
                  bus_a.TP_SEL, bus_a.TP_COLOR, bus_a.SEQ_IDX);
      end
      do_frame(1'b0);
      n_checks++;
      if ({bus_a.TP_SEL, bus_a.TP_COLOR, bus_a.SEQ_IDX} !== {2'b11, 2'b11, 3'd5}) begin
         n_fail++;
         $display("FAIL manual_entry: got sel=%b col=%b idx=%0d expected 11 11 5",
                  bus_a.TP_SEL, bus_a.TP_COLOR, bus_a.SEQ_IDX);
      end
      pulse_step();
      idle(1);
      do_frame(1'b0);
      n_checks++;
      if ({bus_a.TP_SEL, bus_a.TP_COLOR, bus_a.SEQ_IDX} !== {2'b11, 2'b11, 3'd5}) begin
         n_fail++;
         $display("FAIL manual_step_ignored: got sel=%b col=%b idx=%0d expected 11 11 5",
                  bus_a.TP_SEL, bus_a.TP_COLOR, bus_a.SEQ_IDX);
      end
      bus_a.MODE_AUTO = 1'b1;
      idle(2);
      n_checks++;
      if ({bus_a.TP_SEL, bus_a.TP_COLOR} !== 4'b1111) begin
         n_fail++;
         $display("FAIL toggle_on_midframe: got sel=%b col=%b expected 11 11", bus_a.TP_SEL, bus_a.TP_COLOR);
      end
      for (int k = 0; k < 4; k++) begin
         do_frame(1'b0);
         n_checks++;
         if ({bus_a.SEQ_IDX, bus_a.TP_SEL, bus_a.TP_COLOR} !==
             {3'(exp_idx[k]), pl_sel[exp_idx[k]], pl_col[exp_idx[k]]}) begin
            n_fail++;
            $display("FAIL resume[%0d]: got idx=%0d sel=%b col=%b expected idx=%0d sel=%b col=%b", k,
                     bus_a.SEQ_IDX, bus_a.TP_SEL, bus_a.TP_COLOR,
                     exp_idx[k], pl_sel[exp_idx[k]], pl_col[exp_idx[k]]);
         end
      end
   endtask

   task automatic test_breath;
      bus_a.MODE_AUTO = 1'b0;
      while (frames < 620) begin
         do_frame(1'b0);
         n_checks++;
         if (bus_a.BREATH_LEVEL !== 8'(exp_level(frames, 1))) begin
            n_fail++;
            $display("FAIL breath_div1[f=%0d]: got %0d expected %0d", frames, bus_a.BREATH_LEVEL, exp_level(frames, 1));
         end
         n_checks++;
         if (bus_b.BREATH_LEVEL !== 8'(exp_level(frames, 2))) begin
            n_fail++;
            $display("FAIL breath_div2[f=%0d]: got %0d expected %0d", frames, bus_b.BREATH_LEVEL, exp_level(frames, 2));
         end
         n_checks++;
         if (bus_a.FRAME_CNT !== 16'(frames)) begin
            n_fail++; $display("FAIL breath_cnt[f=%0d]: got %0d expected %0d", frames, bus_a.FRAME_CNT, frames);
         end
      end
   endtask

   task automatic test_reset_mid;
      idle(1);
      rst_n = 1'b0;
      idle(1);
      rst_n = 1'b1;
      frames = 0;
      bus_a.MODE_AUTO = 1'b1;
      // Entry frame shows index 0; index 4 is reached on frame 13.
      repeat (13) do_frame(1'b0);
      n_checks++;
      if ({bus_a.SEQ_IDX, bus_a.TP_SEL, bus_a.TP_COLOR, bus_a.BREATH_LEVEL} !== {3'd4, 2'b01, 2'b11, 8'd13}) begin
         n_fail++;
         $display("FAIL pre_reset_state: got idx=%0d sel=%b col=%b lvl=%0d expected 4 01 11 13",
                  bus_a.SEQ_IDX, bus_a.TP_SEL, bus_a.TP_COLOR, bus_a.BREATH_LEVEL);
      end
      idle(1);
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({bus_a.TP_SEL, bus_a.TP_COLOR, bus_a.BREATH_LEVEL, bus_a.SEQ_IDX, bus_a.FRAME_CNT} !== 31'd0) begin
         n_fail++;
         $display("FAIL async_reset: got sel=%b col=%b lvl=%0d idx=%0d cnt=%0d expected all 0",
                  bus_a.TP_SEL, bus_a.TP_COLOR, bus_a.BREATH_LEVEL, bus_a.SEQ_IDX, bus_a.FRAME_CNT);
      end
      idle(2);
      rst_n = 1'b1;
      frames = 0;
      do_frame(1'b0);
      n_checks++;
      if ({bus_a.FRAME_CNT, bus_a.SEQ_IDX, bus_a.TP_SEL, bus_a.TP_COLOR, bus_a.BREATH_LEVEL} !==
          {16'd1, 3'd0, 2'b00, 2'b00, 8'd1}) begin
         n_fail++;
         $display("FAIL post_reset_frame: got cnt=%0d idx=%0d sel=%b col=%b lvl=%0d expected 1 0 00 00 1",
                  bus_a.FRAME_CNT, bus_a.SEQ_IDX, bus_a.TP_SEL, bus_a.TP_COLOR, bus_a.BREATH_LEVEL);
      end
   endtask

   initial begin
      test_reset();
      test_auto_playlist();
      test_step();
      test_mode_toggle();
      test_breath();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
